// File: rtl/bbcpu_pkg.sv
// Shared definitions for the 8-bit bus CPU control path: opcodes, T-step
// encodings and control-word bit positions.
package bbcpu_pkg;

   localparam int OP_NOP = 0;
   localparam int OP_LDA = 1;
   localparam int OP_ADD = 2;
   localparam int OP_SUB = 3;
   localparam int OP_STA = 4;
   localparam int OP_LDI = 5;
   localparam int OP_JMP = 6;
   localparam int OP_JC  = 7;
   localparam int OP_JZ  = 8;
   localparam int OP_OUT = 14;
   localparam int OP_HLT = 15;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } step_t;

   localparam int CW_PC_ENABLE        = 0;
   localparam int CW_PC_INC           = 1;
   localparam int CW_PC_LOAD          = 2;
   localparam int CW_MAR_WRITE        = 3;
   localparam int CW_RAM_ENABLE       = 4;
   localparam int CW_RAM_WRITE        = 5;
   localparam int CW_OUT_WRITE        = 6;
   localparam int CW_IR_ENABLE        = 7;
   localparam int CW_IR_WRITE         = 8;
   localparam int CW_ALU_ENABLE       = 9;
   localparam int CW_REGA_ENABLE      = 10;
   localparam int CW_REGB_ENABLE      = 11;
   localparam int CW_REGA_WRITE       = 12;
   localparam int CW_REGB_WRITE       = 13;
   localparam int CW_SUB_ENABLE       = 14;
   localparam int CW_CARRY_WRITE      = 15;
   localparam int CW_ZERO_WRITE       = 16;
   localparam int CW_HALT             = 17;
   localparam int CW_W                = 18;

   typedef logic [CW_W-1:0] ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational microcode: {opcode, step, flags} -> control word and "last".
// Opcode 8 decodes as JZ only when ZERO_FLAG_EN is defined.
module control_decode
   import bbcpu_pkg::*;
#(
   parameter int OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [2:0]          step,
   input  logic                carry_flag,
`ifdef ZERO_FLAG_EN
   input  logic                zero_flag,
`endif
   output ctrl_t               ctrl,
   output logic                last
);

   always_comb begin
      ctrl = '0;
      last = 1'b1;
      case (step)
         T0: begin
            ctrl[CW_PC_ENABLE] = 1'b1;
            ctrl[CW_MAR_WRITE] = 1'b1;
            last               = 1'b0;
         end
         T1: begin
            ctrl[CW_RAM_ENABLE] = 1'b1;
            ctrl[CW_IR_WRITE]   = 1'b1;
            ctrl[CW_PC_INC]     = 1'b1;
            last                = 1'b0;
         end
         T2: begin
            case (opcode)
               OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD),
               OPCODE_W'(OP_SUB), OPCODE_W'(OP_STA): begin
                  ctrl[CW_IR_ENABLE] = 1'b1;
                  ctrl[CW_MAR_WRITE] = 1'b1;
                  last               = 1'b0;
               end
               OPCODE_W'(OP_LDI): begin
                  ctrl[CW_IR_ENABLE]  = 1'b1;
                  ctrl[CW_REGA_WRITE] = 1'b1;
               end
               OPCODE_W'(OP_JMP): begin
                  ctrl[CW_IR_ENABLE] = 1'b1;
                  ctrl[CW_PC_LOAD]   = 1'b1;
               end
               OPCODE_W'(OP_JC): begin
                  ctrl[CW_IR_ENABLE] = carry_flag;
                  ctrl[CW_PC_LOAD]   = carry_flag;
               end
`ifdef ZERO_FLAG_EN
               OPCODE_W'(OP_JZ): begin
                  ctrl[CW_IR_ENABLE] = zero_flag;
                  ctrl[CW_PC_LOAD]   = zero_flag;
               end
`endif
               OPCODE_W'(OP_OUT): begin
                  ctrl[CW_REGA_ENABLE] = 1'b1;
                  ctrl[CW_OUT_WRITE]   = 1'b1;
               end
               // Halt parks the sequencer in T2; the step must not advance.
               OPCODE_W'(OP_HLT): begin
                  ctrl[CW_HALT] = 1'b1;
                  last          = 1'b0;
               end
               default: ;
            endcase
         end
         T3: begin
            case (opcode)
               OPCODE_W'(OP_LDA): begin
                  ctrl[CW_RAM_ENABLE] = 1'b1;
                  ctrl[CW_REGA_WRITE] = 1'b1;
               end
               OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
                  ctrl[CW_RAM_ENABLE] = 1'b1;
                  ctrl[CW_REGB_WRITE] = 1'b1;
                  last                = 1'b0;
               end
               OPCODE_W'(OP_STA): begin
                  ctrl[CW_REGA_ENABLE] = 1'b1;
                  ctrl[CW_RAM_WRITE]   = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            if (opcode == OPCODE_W'(OP_ADD) || opcode == OPCODE_W'(OP_SUB)) begin
               ctrl[CW_ALU_ENABLE]  = 1'b1;
               ctrl[CW_REGA_WRITE]  = 1'b1;
               ctrl[CW_CARRY_WRITE] = 1'b1;
               ctrl[CW_ZERO_WRITE]  = 1'b1;
               ctrl[CW_SUB_ENABLE]  = (opcode == OPCODE_W'(OP_SUB));
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: IR, T-step counter, flags and control fan-out.
// Optional ZERO_FLAG_EN adds the zero flag register, its port and JZ.
module control_sequencer
   import bbcpu_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int OPCODE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             carry_in,
   output logic [WIDTH-1:0] ir_bus_out,
   output logic             ir_enable,
   output logic             pc_enable,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             mar_write,
   output logic             ram_enable,
   output logic             ram_write,
   output logic             out_write,
   output logic             alu_enable,
   output logic             rega_enable,
   output logic             regb_enable,
   output logic             rega_write_enable,
   output logic             regb_write_enable,
   output logic             sub_enable,
`ifdef ZERO_FLAG_EN
   output logic             zero_flag,
`endif
   output logic             halted,
   output logic [2:0]       step
);

   logic [WIDTH-1:0] ir_q;
   logic [2:0]       step_q;
   logic             carry_flag_q;
   logic             halted_q;
   ctrl_t            ctrl;
   logic             last;
   logic             drive;

`ifdef ZERO_FLAG_EN
   logic             zero_flag_q;
`endif

   control_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .opcode     (ir_q[WIDTH-1 -: OPCODE_W]),
      .step       (step_q),
      .carry_flag (carry_flag_q),
`ifdef ZERO_FLAG_EN
      .zero_flag  (zero_flag_q),
`endif
      .ctrl       (ctrl),
      .last       (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q         <= '0;
         step_q       <= T0;
         carry_flag_q <= 1'b0;
         halted_q     <= 1'b0;
`ifdef ZERO_FLAG_EN
         zero_flag_q  <= 1'b0;
`endif
      end else if (!halted_q) begin
         if (ctrl[CW_IR_WRITE])
            ir_q <= bus_in;
         if (ctrl[CW_CARRY_WRITE])
            carry_flag_q <= carry_in;
`ifdef ZERO_FLAG_EN
         if (ctrl[CW_ZERO_WRITE])
            zero_flag_q <= (bus_in == '0);
`endif
         // Decode flags T4 and illegal steps as last, so the counter wraps to T0.
         if (ctrl[CW_HALT])
            halted_q <= 1'b1;
         else if (last)
            step_q <= T0;
         else
            step_q <= step_q + 3'd1;
      end
   end

`ifndef ZERO_FLAG_EN
   logic unused_zero_write;
   assign unused_zero_write = ctrl[CW_ZERO_WRITE];
`else
   assign zero_flag = zero_flag_q;
`endif

   // Enables are silenced combinationally while reset is held or once halted.
   assign drive = rst_n & ~halted_q;

   assign ir_enable         = drive & ctrl[CW_IR_ENABLE];
   assign pc_enable         = drive & ctrl[CW_PC_ENABLE];
   assign pc_inc            = drive & ctrl[CW_PC_INC];
   assign pc_load           = drive & ctrl[CW_PC_LOAD];
   assign mar_write         = drive & ctrl[CW_MAR_WRITE];
   assign ram_enable        = drive & ctrl[CW_RAM_ENABLE];
   assign ram_write         = drive & ctrl[CW_RAM_WRITE];
   assign out_write         = drive & ctrl[CW_OUT_WRITE];
   assign alu_enable        = drive & ctrl[CW_ALU_ENABLE];
   assign rega_enable       = drive & ctrl[CW_REGA_ENABLE];
   assign regb_enable       = drive & ctrl[CW_REGB_ENABLE];
   assign rega_write_enable = drive & ctrl[CW_REGA_WRITE];
   assign regb_write_enable = drive & ctrl[CW_REGB_WRITE];
   assign sub_enable        = drive & ctrl[CW_SUB_ENABLE];

   assign ir_bus_out = ir_enable ? {{OPCODE_W{1'b0}}, ir_q[WIDTH-OPCODE_W-1:0]} : '0;
   assign halted     = halted_q;
   assign step       = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares. Honours ZERO_FLAG_EN.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] bus_in = 8'h00;
   logic       carry_in = 1'b0;
   logic [7:0] ir_bus_out;
   logic       ir_enable, pc_enable, pc_inc, pc_load, mar_write, ram_enable;
   logic       ram_write, out_write, alu_enable, rega_enable, regb_enable;
   logic       rega_write_enable, regb_write_enable, sub_enable, halted;
   logic [2:0] step;
`ifdef ZERO_FLAG_EN
   logic       zero_flag;
`endif

   control_sequencer #(.WIDTH(8), .OPCODE_W(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus_in            (bus_in),
      .carry_in          (carry_in),
      .ir_bus_out        (ir_bus_out),
      .ir_enable         (ir_enable),
      .pc_enable         (pc_enable),
      .pc_inc            (pc_inc),
      .pc_load           (pc_load),
      .mar_write         (mar_write),
      .ram_enable        (ram_enable),
      .ram_write         (ram_write),
      .out_write         (out_write),
      .alu_enable        (alu_enable),
      .rega_enable       (rega_enable),
      .regb_enable       (regb_enable),
      .rega_write_enable (rega_write_enable),
      .regb_write_enable (regb_write_enable),
      .sub_enable        (sub_enable),
`ifdef ZERO_FLAG_EN
      .zero_flag         (zero_flag),
`endif
      .halted            (halted),
      .step              (step)
   );

   always #5 clk = ~clk;

   localparam logic [13:0] E_IR  = 14'h2000, E_PC  = 14'h1000, E_INC = 14'h0800,
                           E_LD  = 14'h0400, E_MAR = 14'h0200, E_RAM = 14'h0100,
                           E_RW  = 14'h0080, E_OUT = 14'h0040, E_ALU = 14'h0020,
                           E_AEN = 14'h0010, E_BEN = 14'h0008, E_AWE = 14'h0004,
                           E_BWE = 14'h0002, E_SUB = 14'h0001, E_NONE = 14'h0000;

   typedef struct {
      string      name;
      logic [13:0] en;
      logic [2:0]  st;
      logic        h;
      logic [7:0]  irb;
      logic        zf;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   passed = 0;
   logic ezf = 1'b0;

   wire [13:0] en_act = {ir_enable, pc_enable, pc_inc, pc_load, mar_write, ram_enable,
                         ram_write, out_write, alu_enable, rega_enable, regb_enable,
                         rega_write_enable, regb_write_enable, sub_enable};

   task automatic tick(input logic r, input logic [7:0] b, input logic c, input string nm,
                       input logic [13:0] en, input logic [2:0] st, input logic h,
                       input logic [7:0] irb);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n    = r;
      bus_in   = b;
      carry_in = c;
      e.name = nm; e.en = en; e.st = st; e.h = h; e.irb = irb; e.zf = ezf;
      sbq.push_back(e);
   endtask

   task automatic fetch(input logic [7:0] irv, input string nm);
      tick(1'b1, 8'h00, 1'b0, {nm, "_t0"}, E_PC | E_MAR, 3'd0, 1'b0, 8'h00);
      tick(1'b1, irv,   1'b0, {nm, "_t1"}, E_RAM | E_INC, 3'd1, 1'b0, 8'h00);
   endtask

   // Monitor: every cycle with a queued expectation is compared at negedge.
   initial begin : monitor
      exp_t e;
      logic ok;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e  = sbq.pop_front();
            ok = (en_act === e.en) && (step === e.st) && (halted === e.h) &&
                 (ir_bus_out === e.irb);
`ifdef ZERO_FLAG_EN
            ok = ok && (zero_flag === e.zf);
`endif
            checks++;
            if (ok) passed++;
            else
               $display("FAIL %s: got en=%h step=%0d halted=%b irb=%h, expected en=%h step=%0d halted=%b irb=%h",
                        e.name, en_act, step, halted, ir_bus_out, e.en, e.st, e.h, e.irb);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      tick(1'b0, 8'h00, 1'b0, "reset0", E_NONE, 3'd0, 1'b0, 8'h00);
      tick(1'b0, 8'h00, 1'b0, "reset1", E_NONE, 3'd0, 1'b0, 8'h00);

      fetch(8'h5A, "ldi");
      tick(1'b1, 8'h00, 1'b0, "ldi_t2", E_IR | E_AWE, 3'd2, 1'b0, 8'h0A);

      fetch(8'h2F, "add");
      tick(1'b1, 8'h00, 1'b0, "add_t2", E_IR | E_MAR, 3'd2, 1'b0, 8'h0F);
      tick(1'b1, 8'h00, 1'b0, "add_t3", E_RAM | E_BWE, 3'd3, 1'b0, 8'h00);
      tick(1'b1, 8'h12, 1'b1, "add_t4", E_ALU | E_AWE, 3'd4, 1'b0, 8'h00);

      fetch(8'h73, "jc_taken");
      tick(1'b1, 8'h00, 1'b0, "jc_taken_t2", E_IR | E_LD, 3'd2, 1'b0, 8'h03);

      fetch(8'h3F, "sub");
      tick(1'b1, 8'h00, 1'b0, "sub_t2", E_IR | E_MAR, 3'd2, 1'b0, 8'h0F);
      tick(1'b1, 8'h00, 1'b0, "sub_t3", E_RAM | E_BWE, 3'd3, 1'b0, 8'h00);
      tick(1'b1, 8'h00, 1'b0, "sub_t4", E_ALU | E_AWE | E_SUB, 3'd4, 1'b0, 8'h00);
      ezf = 1'b1;

      fetch(8'h73, "jc_not");
      tick(1'b1, 8'h00, 1'b0, "jc_not_t2", E_NONE, 3'd2, 1'b0, 8'h00);

      fetch(8'h85, "op8");
`ifdef ZERO_FLAG_EN
      tick(1'b1, 8'h00, 1'b0, "jz_t2", E_IR | E_LD, 3'd2, 1'b0, 8'h05);
`else
      tick(1'b1, 8'h00, 1'b0, "op8_nop_t2", E_NONE, 3'd2, 1'b0, 8'h00);
`endif

      fetch(8'h4C, "sta");
      tick(1'b1, 8'h00, 1'b0, "sta_t2", E_IR | E_MAR, 3'd2, 1'b0, 8'h0C);
      tick(1'b1, 8'h00, 1'b0, "sta_t3", E_AEN | E_RW, 3'd3, 1'b0, 8'h00);

      fetch(8'hE0, "out");
      tick(1'b1, 8'h00, 1'b0, "out_t2", E_AEN | E_OUT, 3'd2, 1'b0, 8'h00);

      fetch(8'h67, "jmp");
      tick(1'b1, 8'h00, 1'b0, "jmp_t2", E_IR | E_LD, 3'd2, 1'b0, 8'h07);

      fetch(8'h00, "nop");
      tick(1'b1, 8'h00, 1'b0, "nop_t2", E_NONE, 3'd2, 1'b0, 8'h00);

      fetch(8'h19, "lda");
      tick(1'b1, 8'h00, 1'b0, "lda_t2", E_IR | E_MAR, 3'd2, 1'b0, 8'h09);
      tick(1'b1, 8'h00, 1'b0, "lda_t3", E_RAM | E_AWE, 3'd3, 1'b0, 8'h00);

      fetch(8'h9F, "illegal");
      tick(1'b1, 8'h00, 1'b0, "illegal_t2", E_NONE, 3'd2, 1'b0, 8'h00);

      fetch(8'h21, "add2");
      tick(1'b1, 8'h00, 1'b0, "add2_t2", E_IR | E_MAR, 3'd2, 1'b0, 8'h01);
      tick(1'b1, 8'h00, 1'b0, "add2_t3", E_RAM | E_BWE, 3'd3, 1'b0, 8'h00);
      tick(1'b1, 8'h00, 1'b1, "add2_t4", E_ALU | E_AWE, 3'd4, 1'b0, 8'h00);

      fetch(8'h21, "add_abort");
      tick(1'b1, 8'h00, 1'b0, "add_abort_t2", E_IR | E_MAR, 3'd2, 1'b0, 8'h01);
      ezf = 1'b0;
      tick(1'b0, 8'h00, 1'b1, "rst_mid_t3", E_NONE, 3'd0, 1'b0, 8'h00);
      tick(1'b0, 8'h00, 1'b1, "rst_hold", E_NONE, 3'd0, 1'b0, 8'h00);

      fetch(8'h73, "jc_after_rst");
      tick(1'b1, 8'h00, 1'b0, "jc_after_rst_t2", E_NONE, 3'd2, 1'b0, 8'h00);

      fetch(8'hF0, "hlt");
      tick(1'b1, 8'h00, 1'b0, "hlt_t2", E_NONE, 3'd2, 1'b0, 8'h00);
      for (int i = 0; i < 20; i++)
         tick(1'b1, 8'h00, 1'b1, "hlt_hold", E_NONE, 3'd2, 1'b1, 8'h00);
      tick(1'b0, 8'h00, 1'b0, "hlt_rst", E_NONE, 3'd0, 1'b0, 8'h00);

      fetch(8'h5A, "ldi_resume");
      tick(1'b1, 8'h00, 1'b0, "ldi_resume_t2", E_IR | E_AWE, 3'd2, 1'b0, 8'h0A);
      fetch(8'h00, "after_resume");

      repeat (3) @(posedge clk);
      checks++;
      if (sbq.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
